// File: rtl/spi_reg_burst.sv
// SPI-slave register bridge with burst auto-increment.
// Decodes a header (rw, width, inc, address) shifted in on SPI rises, then
// moves byte/half/word beats between the SPI host and one peripheral bus port.
module spi_reg_burst #(
    parameter int ADDR_W     = 6,
    parameter int DUMMY_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs_n,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       data_in,
    output logic [1:0]        data_write_n,
    output logic [1:0]        data_read_n,
    input  logic [31:0]       data_out,
    input  logic              data_ready,
    output logic              txn_err,
    output logic              busy
);
    localparam int HDR_BITS = 4 + ADDR_W;
    localparam int CNT_W    = 8;
    localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(HDR_BITS - 1);
    localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_BITS - 1);

    typedef enum logic [2:0] {IDLE, HDR, WDATA, RTURN, RDATA} state_t;

    state_t            state_q, state_d;
    logic              spi_clk_q, spi_clk_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [30:0]       shift_q, shift_d;
    logic [1:0]        w_q, w_d;
    logic              inc_q, inc_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [31:0]       data_in_q, data_in_d;
    logic [1:0]        write_n_q, write_n_d;
    logic [1:0]        read_n_q, read_n_d;
    logic [31:0]       hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic [31:0]       out_q, out_d;
    logic              miso_q, miso_d;
    logic              txn_err_q, txn_err_d;
    logic              missed_q, missed_d;
    logic              pend_q, pend_d;

    logic              spi_rise, spi_fall;
    logic [31:0]       shift_in;
    logic [1:0]        hdr_w_raw, hdr_w;
    logic              hdr_rw, hdr_inc;
    logic [ADDR_W-1:0] hdr_addr;
    logic [CNT_W-1:0]  beat_last;
    logic [ADDR_W-1:0] step;
    logic              req_out, hdr_done, wr_done, dummy_done, first_fall, late, ready_cap;
    logic [31:0]       aligned;

    function automatic logic [31:0] beat_mask(input logic [1:0] w);
        case (w)
            2'b00:   return 32'h0000_00FF;
            2'b01:   return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] beat_align(input logic [1:0] w, input logic [31:0] d);
        case (w)
            2'b00:   return {d[7:0], 24'h0};
            2'b01:   return {d[15:0], 16'h0};
            default: return d;
        endcase
    endfunction

    assign spi_rise   = ~spi_cs_n & spi_clk & ~spi_clk_q;
    assign spi_fall   = ~spi_cs_n & ~spi_clk & spi_clk_q;
    assign shift_in   = {shift_q, spi_mosi};
    assign hdr_rw     = shift_in[HDR_BITS-1];
    assign hdr_w_raw  = shift_in[HDR_BITS-2 -: 2];
    assign hdr_w      = (hdr_w_raw == 2'b11) ? 2'b10 : hdr_w_raw;
    assign hdr_inc    = shift_in[HDR_BITS-4];
    assign hdr_addr   = shift_in[ADDR_W-1:0];
    assign beat_last  = (w_q == 2'b00) ? CNT_W'(7) : (w_q == 2'b01) ? CNT_W'(15) : CNT_W'(31);
    assign step       = ADDR_W'(1) << w_q;
    assign req_out    = (read_n_q != 2'b11);
    assign hdr_done   = (state_q == HDR)   && spi_rise && (cnt_q == HDR_LAST);
    assign wr_done    = (state_q == WDATA) && spi_rise && (cnt_q == beat_last);
    assign dummy_done = (state_q == RTURN) && spi_rise && (cnt_q == DUMMY_LAST);
    assign first_fall = (state_q == RDATA) && spi_fall && (cnt_q == '0);
    assign late       = first_fall && !hold_valid_q;
    assign ready_cap  = data_ready && req_out;
    assign aligned    = beat_align(w_q, hold_q);

    // State register for the transfer FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: CS high always returns to IDLE, header rw picks the data phase.
    always_comb begin
        state_d = state_q;
        if (spi_cs_n) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = HDR;
                HDR:     if (hdr_done) state_d = hdr_rw ? WDATA : RTURN;
                RTURN:   if (dummy_done) state_d = RDATA;
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath: bit counting, beat assembly, bus requests, read hold and MISO shifting.
    always_comb begin
        spi_clk_d    = spi_clk;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        w_d          = w_q;
        inc_d        = inc_q;
        address_d    = address_q;
        data_in_d    = data_in_q;
        write_n_d    = 2'b11;
        read_n_d     = read_n_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        out_d        = out_q;
        miso_d       = miso_q;
        txn_err_d    = 1'b0;
        missed_d     = missed_q;
        pend_d       = pend_q;

        if (spi_rise) begin
            case (state_q)
                HDR: begin
                    shift_d = shift_in[30:0];
                    cnt_d   = hdr_done ? '0 : cnt_q + 1'b1;
                end
                WDATA: begin
                    shift_d = shift_in[30:0];
                    cnt_d   = wr_done ? '0 : cnt_q + 1'b1;
                end
                RTURN:   cnt_d = dummy_done ? '0 : cnt_q + 1'b1;
                RDATA:   cnt_d = (cnt_q == beat_last) ? '0 : cnt_q + 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end

        if (hdr_done) begin
            w_d       = hdr_w;
            inc_d     = hdr_inc;
            address_d = hdr_addr;
            if (!hdr_rw) begin
                read_n_d     = hdr_w;
                hold_valid_d = 1'b0;
                missed_d     = 1'b0;
                pend_d       = 1'b0;
            end
        end

        if (wr_done) begin
            data_in_d = shift_in & beat_mask(w_q);
            write_n_d = w_q;
        end

        if ((write_n_q != 2'b11) && inc_q) address_d = address_q + step;

        if (pend_q && !req_out) begin
            read_n_d = w_q;
            pend_d   = 1'b0;
        end

        if (ready_cap) begin
            read_n_d = 2'b11;
            missed_d = 1'b0;
            if (!missed_q && !late) begin
                hold_d       = data_out & beat_mask(w_q);
                hold_valid_d = 1'b1;
            end
        end

        if (first_fall) begin
            if (hold_valid_q) begin
                miso_d       = aligned[31];
                out_d        = aligned << 1;
                hold_valid_d = 1'b0;
            end else begin
                txn_err_d = 1'b1;
                miso_d    = 1'b0;
                out_d     = '0;
                if (req_out && !data_ready) missed_d = 1'b1;
            end
            if (inc_q) address_d = address_q + step;
            if (!req_out || data_ready) read_n_d = w_q;
            else                        pend_d   = 1'b1;
        end else if ((state_q == RDATA) && spi_fall) begin
            miso_d = out_q[31];
            out_d  = out_q << 1;
        end

        if (spi_cs_n) begin
            cnt_d        = '0;
            read_n_d     = 2'b11;
            miso_d       = 1'b0;
            hold_valid_d = 1'b0;
            missed_d     = 1'b0;
            pend_d       = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_clk_q    <= 1'b0;
            cnt_q        <= '0;
            shift_q      <= '0;
            w_q          <= 2'b00;
            inc_q        <= 1'b0;
            address_q    <= '0;
            data_in_q    <= '0;
            write_n_q    <= 2'b11;
            read_n_q     <= 2'b11;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            out_q        <= '0;
            miso_q       <= 1'b0;
            txn_err_q    <= 1'b0;
            missed_q     <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            spi_clk_q    <= spi_clk_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            w_q          <= w_d;
            inc_q        <= inc_d;
            address_q    <= address_d;
            data_in_q    <= data_in_d;
            write_n_q    <= write_n_d;
            read_n_q     <= read_n_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            out_q        <= out_d;
            miso_q       <= miso_d;
            txn_err_q    <= txn_err_d;
            missed_q     <= missed_d;
            pend_q       <= pend_d;
        end
    end

    assign spi_miso     = miso_q;
    assign address      = address_q;
    assign data_in      = data_in_q;
    assign data_write_n = write_n_q;
    assign data_read_n  = read_n_q;
    assign txn_err      = txn_err_q;
    assign busy         = (state_q != IDLE) || req_out;

endmodule

// File: tb/tb_spi_reg_burst.sv
// Self-checking bench for spi_reg_burst: bit-level SPI host, peripheral model
// backed by a register array, and a beat-level reference for expected traffic.
module tb_spi_reg_burst;
    localparam int ADDR_W     = 6;
    localparam int DUMMY_BITS = 8;
    localparam int HALF       = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_cs_n;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        txn_err;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
        logic [1:0]  wn;
    } wr_t;
    typedef struct {
        logic [5:0] a;
        logic [1:0] rn;
    } rq_t;

    wr_t         wr_q[$];
    rq_t         req_q[$];
    logic [31:0] mem [64];
    logic [31:0] rd_got [4];
    int          lat        = 3;
    int          err_pulses = 0;
    logic [1:0]  prev_rn    = 2'b11;
    logic        serving    = 1'b0;
    int          wcnt       = 0;

    spi_reg_burst #(.ADDR_W(ADDR_W), .DUMMY_BITS(DUMMY_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .address(address),
        .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out), .data_ready(data_ready), .txn_err(txn_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Bus monitor: records write strobes, new read requests and error pulses.
    always @(negedge clk) begin
        if (data_write_n != 2'b11) wr_q.push_back('{address, data_in, data_write_n});
        if (data_read_n != 2'b11 && prev_rn == 2'b11) req_q.push_back('{address, data_read_n});
        if (txn_err) err_pulses++;
        prev_rn = data_read_n;
    end

    // Peripheral model: answers a held request after lat cycles from the register array.
    always @(negedge clk) begin
        data_ready = 1'b0;
        data_out   = $urandom;
        if (!rst_n || data_read_n == 2'b11) begin
            serving = 1'b0;
            wcnt    = 0;
        end else begin
            if (!serving) begin
                serving = 1'b1;
                wcnt    = 0;
            end
            wcnt++;
            if (wcnt == lat) begin
                data_ready = 1'b1;
                data_out   = mem[address];
            end
        end
    end

    function automatic logic [1:0] eff_w(input logic [1:0] w);
        return (w == 2'b11) ? 2'b10 : w;
    endfunction

    function automatic int beat_bits(input logic [1:0] w);
        return 8 << eff_w(w);
    endfunction

    function automatic logic [31:0] beat_mask(input logic [1:0] w);
        if (beat_bits(w) >= 32) return 32'hFFFF_FFFF;
        return (32'h1 << beat_bits(w)) - 32'h1;
    endfunction

    function automatic logic [5:0] beat_addr(input logic [5:0] a, input logic inc,
                                             input logic [1:0] w, input int k);
        if (!inc) return a;
        return 6'((int'(a) + k * (1 << eff_w(w))) % 64);
    endfunction

    task automatic spi_start();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_stop();
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_bit(input logic mo, output logic mi);
        spi_mosi = mo;
        repeat (HALF) @(negedge clk);
        mi = spi_miso;
        spi_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic send_header(input logic rw, input logic [1:0] w, input logic inc,
                               input logic [5:0] a);
        logic [9:0] h;
        logic       mi;
        h = {rw, w, inc, a};
        for (int i = 9; i >= 0; i--) spi_bit(h[i], mi);
    endtask

    task automatic do_write(input logic [1:0] w, input logic inc, input logic [5:0] a,
                            input int nb, input logic [31:0] beats [4]);
        logic mi;
        logic [31:0] b;
        spi_start();
        send_header(1'b1, w, inc, a);
        for (int k = 0; k < nb; k++) begin
            b = beats[k];
            for (int i = beat_bits(w) - 1; i >= 0; i--) spi_bit(b[i], mi);
        end
        spi_stop();
    endtask

    task automatic do_read(input logic [1:0] w, input logic inc, input logic [5:0] a,
                           input int nb);
        logic mi;
        spi_start();
        send_header(1'b0, w, inc, a);
        for (int i = 0; i < DUMMY_BITS; i++) spi_bit(1'($urandom), mi);
        for (int k = 0; k < nb; k++) begin
            rd_got[k] = '0;
            for (int i = 0; i < beat_bits(w); i++) begin
                spi_bit(1'($urandom), mi);
                rd_got[k] = {rd_got[k][30:0], mi};
            end
        end
        spi_stop();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        spi_cs_n = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({spi_miso, address, data_in, data_write_n, data_read_n, txn_err, busy} !==
            {1'b0, 6'h0, 32'h0, 2'b11, 2'b11, 1'b0, 1'b0})
            $display("[TB] FAIL reset_outputs got miso=%b addr=%h din=%h wn=%b rn=%b err=%b busy=%b expected 0/00/0/11/11/0/0",
                     spi_miso, address, data_in, data_write_n, data_read_n, txn_err, busy);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_write();
        logic [31:0] beats [4];
        beats[0] = 32'hDEADBEEF;
        wr_q.delete();
        do_write(2'b10, 1'b0, 6'h05, 1, beats);
        n_checks++;
        if (wr_q.size() !== 1)
            $display("[TB] FAIL single_write_count got %0d expected 1", wr_q.size());
        else if (wr_q[0].a !== 6'h05 || wr_q[0].d !== 32'hDEADBEEF || wr_q[0].wn !== 2'b10)
            $display("[TB] FAIL single_write got a=%h d=%h wn=%b expected a=05 d=deadbeef wn=10",
                     wr_q[0].a, wr_q[0].d, wr_q[0].wn);
        else n_pass++;
    endtask

    task automatic test_burst_write();
        logic [31:0] beats [4];
        logic [5:0]  ea [3];
        ea[0] = 6'h3E; ea[1] = 6'h3F; ea[2] = 6'h00;
        beats[0] = 32'h11; beats[1] = 32'h22; beats[2] = 32'h33;
        wr_q.delete();
        do_write(2'b00, 1'b1, 6'h3E, 3, beats);
        n_checks++;
        if (wr_q.size() !== 3) $display("[TB] FAIL burst_write_count got %0d expected 3", wr_q.size());
        else n_pass++;
        for (int k = 0; k < 3 && k < wr_q.size(); k++) begin
            n_checks++;
            if (wr_q[k].a !== ea[k] || wr_q[k].d !== beats[k] || wr_q[k].wn !== 2'b00)
                $display("[TB] FAIL burst_write_beat%0d got a=%h d=%h wn=%b expected a=%h d=%h wn=00",
                         k, wr_q[k].a, wr_q[k].d, wr_q[k].wn, ea[k], beats[k]);
            else n_pass++;
        end
    endtask

    task automatic test_random_writes(input int iters);
        logic [31:0] beats [4];
        logic [1:0]  w;
        logic        inc;
        logic [5:0]  a;
        int          nb;
        logic [31:0] ed;
        logic [5:0]  ea;
        for (int it = 0; it < iters; it++) begin
            w   = 2'($urandom_range(0, 3));
            inc = 1'($urandom);
            a   = 6'($urandom);
            nb  = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) beats[k] = $urandom;
            wr_q.delete();
            do_write(w, inc, a, nb, beats);
            n_checks++;
            if (wr_q.size() !== nb) $display("[TB] FAIL rand_write_count got %0d expected %0d", wr_q.size(), nb);
            else n_pass++;
            for (int k = 0; k < nb && k < wr_q.size(); k++) begin
                ea = beat_addr(a, inc, w, k);
                ed = beats[k] & beat_mask(w);
                n_checks++;
                if (wr_q[k].a !== ea || wr_q[k].d !== ed || wr_q[k].wn !== eff_w(w))
                    $display("[TB] FAIL rand_write_beat%0d got a=%h d=%h wn=%b expected a=%h d=%h wn=%b",
                             k, wr_q[k].a, wr_q[k].d, wr_q[k].wn, ea, ed, eff_w(w));
                else n_pass++;
            end
        end
    endtask

    task automatic test_word_read();
        int e0;
        mem[8] = 32'hCAFEF00D;
        lat = 3;
        e0 = err_pulses;
        do_read(2'b10, 1'b0, 6'h08, 1);
        n_checks++;
        if (rd_got[0] !== 32'hCAFEF00D) $display("[TB] FAIL word_read got %h expected cafef00d", rd_got[0]);
        else n_pass++;
        n_checks++;
        if (err_pulses !== e0) $display("[TB] FAIL word_read_txn_err got %0d pulses expected 0", err_pulses - e0);
        else n_pass++;
    endtask

    task automatic test_half_burst_read();
        lat = 4;
        req_q.delete();
        do_read(2'b01, 1'b1, 6'h10, 3);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rd_got[k] !== (mem[6'h10 + 2 * k] & 32'hFFFF))
                $display("[TB] FAIL half_burst_data%0d got %h expected %h", k, rd_got[k], mem[6'h10 + 2 * k] & 32'hFFFF);
            else n_pass++;
            n_checks++;
            if (k >= req_q.size())
                $display("[TB] FAIL half_burst_req%0d got none expected a=%h rn=01", k, 6'h10 + 2 * k);
            else if (req_q[k].a !== 6'(6'h10 + 2 * k) || req_q[k].rn !== 2'b01)
                $display("[TB] FAIL half_burst_req%0d got a=%h rn=%b expected a=%h rn=01",
                         k, req_q[k].a, req_q[k].rn, 6'h10 + 2 * k);
            else n_pass++;
        end
    endtask

    task automatic test_random_reads(input int iters);
        logic [1:0]  w;
        logic        inc;
        logic [5:0]  a;
        int          nb;
        logic [31:0] ed;
        for (int it = 0; it < iters; it++) begin
            w   = 2'($urandom_range(0, 3));
            inc = 1'($urandom);
            a   = 6'($urandom);
            nb  = $urandom_range(1, 3);
            lat = $urandom_range(1, 10);
            do_read(w, inc, a, nb);
            for (int k = 0; k < nb; k++) begin
                ed = mem[beat_addr(a, inc, w, k)] & beat_mask(w);
                n_checks++;
                if (rd_got[k] !== ed)
                    $display("[TB] FAIL rand_read_beat%0d got %h expected %h (w=%b inc=%b a=%h)",
                             k, rd_got[k], ed, w, inc, a);
                else n_pass++;
            end
        end
    endtask

    task automatic test_late_data();
        logic        mi;
        logic [31:0] v;
        int          e0;
        lat = 200;
        e0  = err_pulses;
        spi_start();
        send_header(1'b0, 2'b10, 1'b0, 6'h21);
        for (int i = 0; i < DUMMY_BITS; i++) spi_bit(1'b0, mi);
        v = '0;
        spi_bit(1'b0, mi);
        v = {v[30:0], mi};
        n_checks++;
        if (data_read_n !== 2'b10) $display("[TB] FAIL late_req_held got %b expected 10", data_read_n);
        else n_pass++;
        n_checks++;
        if (err_pulses - e0 !== 1) $display("[TB] FAIL late_txn_err got %0d pulses expected 1", err_pulses - e0);
        else n_pass++;
        for (int i = 1; i < 32; i++) begin
            spi_bit(1'b0, mi);
            v = {v[30:0], mi};
            if (i == 16) begin
                n_checks++;
                if (err_pulses - e0 !== 1)
                    $display("[TB] FAIL late_err_single got %0d pulses expected 1", err_pulses - e0);
                else n_pass++;
            end
        end
        spi_stop();
        n_checks++;
        if (v !== 32'h0) $display("[TB] FAIL late_beat_zero got %h expected 00000000", v);
        else n_pass++;
        n_checks++;
        if (data_read_n !== 2'b11 || busy !== 1'b0)
            $display("[TB] FAIL late_idle got rn=%b busy=%b expected 11/0", data_read_n, busy);
        else n_pass++;
        lat = 3;
    endtask

    task automatic test_abort_write();
        logic mi;
        wr_q.delete();
        spi_start();
        send_header(1'b1, 2'b00, 1'b0, 6'h15);
        for (int i = 0; i < 5; i++) spi_bit(1'($urandom), mi);
        spi_stop();
        n_checks++;
        if (wr_q.size() !== 0) $display("[TB] FAIL abort_write_strobe got %0d strobes expected 0", wr_q.size());
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || address !== 6'h15)
            $display("[TB] FAIL abort_write_idle got busy=%b addr=%h expected 0/15", busy, address);
        else n_pass++;
    endtask

    task automatic test_abort_read();
        logic mi;
        lat = 200;
        spi_start();
        send_header(1'b0, 2'b10, 1'b0, 6'h0A);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, mi);
        repeat (HALF) @(negedge clk);
        n_checks++;
        if (data_read_n !== 2'b10) $display("[TB] FAIL abort_read_pending got %b expected 10", data_read_n);
        else n_pass++;
        spi_cs_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (data_read_n !== 2'b11 || spi_miso !== 1'b0)
            $display("[TB] FAIL abort_read_withdraw got rn=%b miso=%b expected 11/0", data_read_n, spi_miso);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || address !== 6'h0A)
            $display("[TB] FAIL abort_read_idle got busy=%b addr=%h expected 0/0a", busy, address);
        else n_pass++;
        lat = 3;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic mi;
        lat = 200;
        spi_start();
        send_header(1'b0, 2'b10, 1'b1, 6'h2A);
        for (int i = 0; i < 2; i++) spi_bit(1'b0, mi);
        n_checks++;
        if (data_read_n !== 2'b10 || address !== 6'h2A || busy !== 1'b1)
            $display("[TB] FAIL async_pre got rn=%b addr=%h busy=%b expected 10/2a/1", data_read_n, address, busy);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({spi_miso, address, data_in, data_write_n, data_read_n, txn_err, busy} !==
            {1'b0, 6'h0, 32'h0, 2'b11, 2'b11, 1'b0, 1'b0})
            $display("[TB] FAIL async_reset got miso=%b addr=%h din=%h wn=%b rn=%b err=%b busy=%b expected 0/00/0/11/11/0/0",
                     spi_miso, address, data_in, data_write_n, data_read_n, txn_err, busy);
        else n_pass++;
        spi_cs_n = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        lat   = 3;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        test_reset();
        test_single_write();
        test_burst_write();
        test_random_writes(4);
        test_word_read();
        test_half_burst_read();
        test_random_reads(5);
        test_late_data();
        test_abort_write();
        test_abort_read();
        test_async_reset();
        test_random_writes(2);
        test_random_reads(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog so a stuck transfer still ends the run with a report.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout got running expected finished");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "[TB] timeout");
    end

endmodule
